// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two valid/ready clients: grant, issue registered operands, capture result, return it.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (client 0 wins ties); default is round-robin.
module alu_share_arb #(
    parameter int WIDTH = 32,
    parameter int SELW  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_x0,
    input  logic [WIDTH-1:0] req_y0,
    input  logic [SELW-1:0]  req_sel0,
    input  logic [WIDTH-1:0] req_x1,
    input  logic [WIDTH-1:0] req_y1,
    input  logic [SELW-1:0]  req_sel1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_z,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [SELW-1:0]  alu_sel,
    input  logic [WIDTH-1:0] alu_z,
    input  logic             alu_zero,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_reg, state_next;
    logic             gnt_reg;
    logic             win;
    logic             grant_en;
    logic             rsp_en;
    logic             accept;
    logic [WIDTH-1:0] alu_x_reg, alu_y_reg, rsp_z_reg;
    logic [SELW-1:0]  alu_sel_reg;
    logic             rsp_zero_reg;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        win = ~req_valid[0];
    end
`else
    logic last_reg;

    // Ties go to the client that was not served last; a lone requester always wins.
    always_comb begin
        if (&req_valid)
            win = ~last_reg;
        else
            win = ~req_valid[0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_reg <= 1'b1;
        else if (accept)
            last_reg <= win;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|req_valid) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready[gnt_reg]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_en = 1'b0;
        rsp_en   = 1'b0;
        busy     = 1'b1;
        case (state_reg)
            IDLE: begin
                grant_en = |req_valid;
                busy     = 1'b0;
            end
            RESP:    rsp_en = 1'b1;
            default: ;
        endcase
    end

    assign accept = grant_en;

    for (genvar gi = 0; gi < 2; gi++) begin : g_client
        assign req_ready[gi] = grant_en && (win == 1'(gi));
        assign rsp_valid[gi] = rsp_en && (gnt_reg == 1'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_x_reg    <= '0;
            alu_y_reg    <= '0;
            alu_sel_reg  <= '0;
            gnt_reg      <= 1'b0;
            rsp_z_reg    <= '0;
            rsp_zero_reg <= 1'b0;
        end else begin
            if (accept) begin
                alu_x_reg   <= win ? req_x1 : req_x0;
                alu_y_reg   <= win ? req_y1 : req_y0;
                alu_sel_reg <= win ? req_sel1 : req_sel0;
                gnt_reg     <= win;
            end
            if (state_reg == EXEC) begin
                rsp_z_reg    <= alu_z;
                rsp_zero_reg <= alu_zero;
            end
        end
    end

    assign alu_x    = alu_x_reg;
    assign alu_y    = alu_y_reg;
    assign alu_sel  = alu_sel_reg;
    assign rsp_z    = rsp_z_reg;
    assign rsp_zero = rsp_zero_reg;

endmodule

// File: tb/tb_alu_share_arb.sv
// Testbench for alu_share_arb: transaction-level reference model with directed and random stimulus.
module tb_alu_share_arb;
    localparam int W = 32;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [W-1:0] req_x0, req_y0, req_x1, req_y1;
    logic [S-1:0] req_sel0, req_sel1;
    logic [W-1:0] rsp_z, alu_x, alu_y, alu_z;
    logic         rsp_zero, alu_zero, busy;
    logic [S-1:0] alu_sel;

    always #5 clk = ~clk;

    alu_share_arb #(.WIDTH(W), .SELW(S)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x0(req_x0), .req_y0(req_y0), .req_sel0(req_sel0),
        .req_x1(req_x1), .req_y1(req_y1), .req_sel1(req_sel1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_z(rsp_z), .rsp_zero(rsp_zero),
        .alu_x(alu_x), .alu_y(alu_y), .alu_sel(alu_sel),
        .alu_z(alu_z), .alu_zero(alu_zero), .busy(busy)
    );

    function automatic logic [W-1:0] stub_z(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [S-1:0] sel);
        case (sel)
            3'd0:    return x + y;
            3'd1:    return x - y;
            default: return x ^ y;
        endcase
    endfunction

    assign alu_z    = stub_z(alu_x, alu_y, alu_sel);
    assign alu_zero = (alu_z == '0);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one outstanding transaction, tracked by age since acceptance.
    int           cyc_cnt = 0;
    bit           m_pending = 0;
    bit           m_last = 1;
    bit           m_client;
    bit           post_reset = 0;
    int           m_acc_cycle;
    logic [W-1:0] m_x = '0, m_y = '0, m_z;
    logic [S-1:0] m_sel = '0;
    bit           m_zero;
    int           acc_client_q[$];
    int           acc_cycle_q[$];
    int           rsp_client_q[$];
    logic [W-1:0] rsp_z_q[$];
    bit           rsp_zero_q[$];

    always @(negedge clk) begin
        bit       w;
        logic [1:0] exp_ready;
        int       age;
        cyc_cnt++;
        if (rst) begin
            m_pending  = 0;
            m_last     = 1;
            m_x        = '0;
            m_y        = '0;
            m_sel      = '0;
            post_reset = 1;
        end else begin
            if (post_reset) begin
                check_eq("reset_rsp_z", rsp_z, 32'd0);
                check_eq("reset_rsp_zero", 32'(rsp_zero), 32'd0);
                post_reset = 0;
            end
            check_eq("alu_x", alu_x, m_x);
            check_eq("alu_y", alu_y, m_y);
            check_eq("alu_sel", 32'(alu_sel), 32'(m_sel));
            if (!m_pending) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                w = !req_valid[0];
`else
                w = (req_valid == 2'b11) ? !m_last : !req_valid[0];
`endif
                exp_ready = (req_valid == 2'b00) ? 2'b00 : (w ? 2'b10 : 2'b01);
                check_eq("idle_req_ready", 32'(req_ready), 32'(exp_ready));
                check_eq("idle_rsp_valid", 32'(rsp_valid), 32'd0);
                check_eq("idle_busy", 32'(busy), 32'd0);
                if (req_valid != 2'b00) begin
                    m_pending   = 1;
                    m_client    = w;
                    m_last      = w;
                    m_x         = w ? req_x1 : req_x0;
                    m_y         = w ? req_y1 : req_y0;
                    m_sel       = w ? req_sel1 : req_sel0;
                    m_z         = stub_z(m_x, m_y, m_sel);
                    m_zero      = (m_z == '0);
                    m_acc_cycle = cyc_cnt;
                    acc_client_q.push_back(int'(w));
                    acc_cycle_q.push_back(cyc_cnt);
                end
            end else begin
                age = cyc_cnt - m_acc_cycle;
                check_eq("busy_req_ready", 32'(req_ready), 32'd0);
                check_eq("busy", 32'(busy), 32'd1);
                if (age == 1) begin
                    check_eq("exec_rsp_valid", 32'(rsp_valid), 32'd0);
                end else begin
                    check_eq("rsp_valid", 32'(rsp_valid), m_client ? 32'd2 : 32'd1);
                    check_eq("rsp_z", rsp_z, m_z);
                    check_eq("rsp_zero", 32'(rsp_zero), 32'(m_zero));
                    if (rsp_ready[m_client]) begin
                        $display("rsp client=%0d z=%0h zero=%0b latency=%0d", m_client, rsp_z, rsp_zero, age);
                        rsp_client_q.push_back(int'(m_client));
                        rsp_z_q.push_back(rsp_z);
                        rsp_zero_q.push_back(rsp_zero);
                        m_pending = 0;
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit c, input logic [W-1:0] x, input logic [W-1:0] y, input logic [S-1:0] sel);
        if (c) begin
            req_x1 = x; req_y1 = y; req_sel1 = sel;
        end else begin
            req_x0 = x; req_y0 = y; req_sel0 = sel;
        end
    endtask

    task automatic rand_ops();
        logic [W-1:0] a;
        a = $urandom;
        set_req(0, a, ($urandom_range(0, 3) == 0) ? a : W'($urandom), S'($urandom_range(0, 2)));
        a = $urandom;
        set_req(1, a, ($urandom_range(0, 3) == 0) ? a : W'($urandom), S'($urandom_range(0, 2)));
    endtask

    initial begin
        int n0, a0, start;
        bit exp_c;
        rst = 1; req_valid = 0; rsp_ready = 0;
        set_req(0, '0, '0, '0);
        set_req(1, '0, '0, '0);
        cyc(3);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("reset_alu_x", alu_x, 32'd0);
        rst = 0;
        cyc(1);

        // Single request
        rsp_ready = 2'b11;
        set_req(0, 32'd56, 32'd7, 3'd0);
        req_valid = 2'b01;
        cyc(1); req_valid = 0;
        cyc(4);
        check_eq("single_count", 32'(rsp_z_q.size()), 32'd1);
        if (rsp_z_q.size() == 1) begin
            check_eq("single_z", rsp_z_q[0], 32'd63);
            check_eq("single_zero", 32'(rsp_zero_q[0]), 32'd0);
            check_eq("single_client", 32'(rsp_client_q[0]), 32'd0);
        end

        // Zero result on client 1
        set_req(1, 32'd7, 32'd7, 3'd1);
        req_valid = 2'b10;
        cyc(1); req_valid = 0;
        cyc(4);
        check_eq("zero_count", 32'(rsp_z_q.size()), 32'd2);
        if (rsp_z_q.size() == 2) begin
            check_eq("zero_z", rsp_z_q[1], 32'd0);
            check_eq("zero_flag", 32'(rsp_zero_q[1]), 32'd1);
            check_eq("zero_client", 32'(rsp_client_q[1]), 32'd1);
        end

        // Contention: both valid for four operations
        acc_client_q.delete();
        req_valid = 2'b11;
        for (int i = 0; i < 40 && acc_client_q.size() < 4; i++) begin
            rand_ops();
            cyc(1);
        end
        req_valid = 0;
        cyc(4);
        check_eq("contend_count", 32'(acc_client_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < acc_client_q.size(); i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_c = 0;
`else
            exp_c = i[0];
`endif
            check_eq("contend_order", 32'(acc_client_q[i]), 32'(exp_c));
        end

        // Back-pressure; the other client's rsp_ready must be ignored
        rsp_ready = 2'b10;
        set_req(0, 32'h1234_5678, 32'h0000_0078, 3'd1);
        req_valid = 2'b01;
        cyc(1); req_valid = 0;
        n0 = rsp_z_q.size();
        cyc(7);
        check_eq("bp_held", 32'(rsp_z_q.size()), 32'(n0));
        rsp_ready = 2'b01;
        cyc(1);
        rsp_ready = 2'b11;
        check_eq("bp_done", 32'(rsp_z_q.size()), 32'(n0 + 1));
        if (rsp_z_q.size() == n0 + 1)
            check_eq("bp_z", rsp_z_q[n0], 32'h1234_5600);
        cyc(2);

        // Reset during EXEC
        n0 = rsp_z_q.size();
        a0 = acc_client_q.size();
        set_req(1, 32'd100, 32'd1, 3'd0);
        req_valid = 2'b10;
        cyc(1);
        req_valid = 0; rst = 1;
        cyc(1);
        rst = 0;
        cyc(6);
        check_eq("rst_accepted", 32'(acc_client_q.size()), 32'(a0 + 1));
        check_eq("rst_no_rsp", 32'(rsp_z_q.size()), 32'(n0));

        // Throughput: client 0 back-to-back with rsp_ready high
        start = acc_cycle_q.size();
        req_valid = 2'b01;
        for (int i = 0; i < 30; i++) begin
            rand_ops();
            cyc(1);
        end
        req_valid = 0;
        cyc(4);
        check_eq("tput_count", 32'(acc_cycle_q.size() - start), 32'd10);
        for (int i = start + 1; i < acc_cycle_q.size(); i++)
            check_eq("tput_interval", 32'(acc_cycle_q[i] - acc_cycle_q[i-1]), 32'd3);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            rand_ops();
            req_valid = 2'($urandom);
            rsp_ready = 2'($urandom);
            rst = ($urandom_range(0, 49) == 0);
            cyc(1);
        end
        rst = 0; req_valid = 0; rsp_ready = 2'b11;
        cyc(5);
        check_eq("drain_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
